sce_schd: RTL and testbench
===========================

SCE_SCHD -- requirements
Module: sce_schd

Interface
REQ-001 SHALL have parameter REQCNT, default 8: number of sub-engine requesters sharing the SCE datapath.
REQ-002 SHALL have parameter TOW, default 16: width of the grant-timeout counter and limit.
REQ-003 SHALL have port clk  input  1: single clock for all logic.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port en  input  REQCNT: per-requester enable, driven from the cr_suben slice.
REQ-006 SHALL have port req  input  REQCNT: level request, held until granted.
REQ-007 SHALL have port rel  input  REQCNT: release pulse from the granted requester.
REQ-008 SHALL have port abort  input  1: global abort pulse, driven by ar_reset.
REQ-009 SHALL have port tocyc  input  TOW: grant timeout in cycles; 0 disables the timeout.
REQ-010 SHALL have port gnt  output  REQCNT: one-hot registered grant.
REQ-011 SHALL have port gntid  output  $clog2(REQCNT): index of the current or last grant.
REQ-012 SHALL have port busy  output  1: high while in GRANT.
REQ-013 SHALL have port done  output  REQCNT: one-cycle pulse on normal release, feeding fr_done.
REQ-014 SHALL have port err  output  REQCNT: one-cycle pulse on timeout or disable-drop, feeding fr_err.

Function
REQ-015 SHALL implement FSM states IDLE and GRANT only.
REQ-016 SHALL treat requester i as eligible when req[i] and en[i] are both high.
REQ-017 SHALL, in IDLE with any eligible requester at cycle N, assert gnt and busy at N+1 and enter GRANT.
REQ-018 SHALL pick round-robin: search starts at pointer ptr and wraps from REQCNT-1 to 0.
REQ-019 SHALL set ptr to (granted index + 1) mod REQCNT at each grant.
REQ-020 SHALL count grant cycles in cnt, cleared on entry to GRANT and saturating at all-ones.
REQ-021 SHALL, in GRANT on rel[gntid], pulse done[gntid] next cycle, drop gnt next cycle, and return to IDLE.
REQ-022 SHALL time out when tocyc!=0 and cnt==tocyc-1, comparing against tocyc live: err[gntid] pulses, gnt drops, FSM goes to IDLE.
REQ-023 SHALL, when en[gntid] falls during GRANT, treat it as timeout: err pulse, drop, IDLE.
REQ-024 SHALL, when rel coincides with a timeout or an en drop, report done only; release wins.
REQ-025 SHALL ignore rel bits not matching gntid.
REQ-026 SHALL keep at least one IDLE cycle between grants, so gnt is low for one cycle between holders.
REQ-027 SHALL, on abort in any state, clear gnt and busy next cycle, go to IDLE, set ptr=0, and emit no done or err.
REQ-028 SHALL let abort take precedence over rel, timeout and new arbitration in the same cycle.
REQ-029 SHALL never assert more than one gnt bit.

Reset
REQ-030 SHALL, under reset, hold the state below until reset deasserts; the first grant is possible on the cycle after deassertion.
REQ-031 Reset state: FSM IDLE; gnt, gntid, busy, done, err, ptr and cnt all 0.

Structure
REQ-032 SHALL place the state enum and the REQCNT default in scedma_pkg.
REQ-033 SHALL use one combinational sub-module, sce_rrpick: inputs eligible vector and ptr; outputs found flag and index.
REQ-034 SHALL register all outputs; no combinational path from inputs to gnt.

Verification
REQ-035 Reset, then req=8'h05, en=8'hFF: gnt=8'h01 at N+1; rel[0] -> done[0] pulse, 1 idle cycle, then gnt=8'h04.
REQ-036 req=8'hFF held, rel issued every 3rd grant cycle: grant order 0,1,…,7,0, one-hot throughout.
REQ-037 tocyc=4, no rel: gnt high exactly 4 cycles, err[gntid] single pulse, busy low after.
REQ-038 tocyc=4 with rel on cycle 4: done pulse only, err stays 0.
REQ-039 Grant held, abort pulse: gnt=0 and busy=0 next cycle, no done/err, next grant search starts at index 0.
REQ-040 Grant to index 2, en[2] dropped: err[2] pulse; a requester with req high and en=0 is never granted.

Source files
------------

// File: rtl/scedma_pkg.sv
// Shared types and defaults for the SCE datapath scheduler.
// Pure declarations: no logic, no latency, no flow control.
package scedma_pkg;

    localparam int REQCNT_DEF = 8;
    localparam int TOW_DEF    = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } sce_state_e;

endpackage

// File: rtl/sce_schd_if.sv
// Request/grant bundle between the sub-engines and the SCE scheduler.
// Wiring only: latency and backpressure are those of the attached scheduler.
interface sce_schd_if #(
    parameter int REQCNT = scedma_pkg::REQCNT_DEF,
    parameter int TOW    = scedma_pkg::TOW_DEF
);

    logic [REQCNT-1:0]         en;
    logic [REQCNT-1:0]         req;
    logic [REQCNT-1:0]         rel;
    logic                      abort;
    logic [TOW-1:0]            tocyc;
    logic [REQCNT-1:0]         gnt;
    logic [$clog2(REQCNT)-1:0] gntid;
    logic                      busy;
    logic [REQCNT-1:0]         done;
    logic [REQCNT-1:0]         err;

    modport master (
        output en, req, rel, abort, tocyc,
        input  gnt, gntid, busy, done, err
    );

    modport slave (
        input  en, req, rel, abort, tocyc,
        output gnt, gntid, busy, done, err
    );

endinterface

// File: rtl/sce_rrpick.sv
// Round-robin pick: first eligible index at or after ptr, wrapping to 0.
// Purely combinational, zero latency; no backpressure.
module sce_rrpick
    import scedma_pkg::*;
#(
    parameter int REQCNT = REQCNT_DEF
) (
    input  logic [REQCNT-1:0]         elig_i,
    input  logic [$clog2(REQCNT)-1:0] ptr_i,
    output logic                      found_o,
    output logic [$clog2(REQCNT)-1:0] idx_o
);

    localparam int IW = $clog2(REQCNT);

    logic          hit;
    logic [IW-1:0] slot;

    always_comb begin
        hit  = 1'b0;
        slot = '0;
        idx_o = '0;
        for (int k = 0; k < REQCNT; k++) begin
            if (int'(ptr_i) + k >= REQCNT) begin
                slot = IW'(int'(ptr_i) + k - REQCNT);
            end else begin
                slot = IW'(int'(ptr_i) + k);
            end
            if (!hit && elig_i[slot]) begin
                hit   = 1'b1;
                idx_o = slot;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/sce_schd.sv
// Round-robin grant FSM for the shared SCE datapath; grant appears 1 cycle after an eligible request.
// Holder keeps the grant until release, timeout, enable drop or abort; others wait with req held.
module sce_schd
    import scedma_pkg::*;
#(
    parameter int REQCNT = REQCNT_DEF,
    parameter int TOW    = TOW_DEF
) (
    input  logic       clk,
    input  logic       reset,
    sce_schd_if.slave  bus
);

    localparam int IW = $clog2(REQCNT);

    sce_state_e        state_q, state_d;
    logic [REQCNT-1:0] gnt_q, gnt_d;
    logic [REQCNT-1:0] done_q, done_d;
    logic [REQCNT-1:0] err_q, err_d;
    logic [IW-1:0]     gntid_q, gntid_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [TOW-1:0]    cnt_q, cnt_d;

    logic [REQCNT-1:0] elig;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              rel_hit;
    logic              en_lost;
    logic              to_hit;

    assign elig = bus.req & bus.en;

    sce_rrpick #(.REQCNT(REQCNT)) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .found_o (pick_vld),
        .idx_o   (pick_idx)
    );

    // tocyc is compared live so software can shorten a grant already in flight.
    assign rel_hit = bus.rel[gntid_q];
    assign en_lost = !bus.en[gntid_q];
    assign to_hit  = (bus.tocyc != '0) && (cnt_q == bus.tocyc - TOW'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gntid_d = gntid_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.abort) begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                    ptr_d  = '0;
                end else if (pick_vld) begin
                    state_d         = ST_GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gntid_d         = pick_idx;
                    busy_d          = 1'b1;
                    cnt_d           = '0;
                    ptr_d           = (pick_idx == IW'(REQCNT - 1)) ? '0 : pick_idx + IW'(1);
                end
            end

            ST_GRANT: begin
                // Abort beats release, which beats timeout and enable loss.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end else if (rel_hit) begin
                    state_d         = ST_IDLE;
                    gnt_d           = '0;
                    busy_d          = 1'b0;
                    done_d[gntid_q] = 1'b1;
                end else if (to_hit || en_lost) begin
                    state_d        = ST_IDLE;
                    gnt_d          = '0;
                    busy_d         = 1'b0;
                    err_d[gntid_q] = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TOW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gntid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gntid_q <= gntid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.gntid = gntid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sce_schd.sv
// Directed bench for sce_schd: reset, round-robin order, release, timeout, abort, enable drop.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_sce_schd;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sce_schd_if #(.REQCNT(8), .TOW(16)) bus ();

    sce_schd #(.REQCNT(8), .TOW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic b, input logic [7:0] d, input logic [7:0] e);
        chk({tag, ".gnt"},   32'(bus.gnt),   32'(g));
        chk({tag, ".gntid"}, 32'(bus.gntid), 32'(id));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".done"},  32'(bus.done),  32'(d));
        chk({tag, ".err"},   32'(bus.err),   32'(e));
    endtask

    initial begin
        logic [7:0] oh;
        logic [2:0] exp_id;

        reset     = 1'b1;
        bus.en    = 8'hFF;
        bus.req   = 8'hFF;
        bus.rel   = 8'h00;
        bus.abort = 1'b0;
        bus.tocyc = 16'd0;
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 8'h00, 8'h00);

        // First grant on the edge right after reset deasserts.
        bus.req = 8'h05;
        reset   = 1'b0;
        tick();
        chk_out("g0_first", 8'h01, 3'd0, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h04;
        bus.rel = 8'h01;
        tick();
        chk_out("g0_rel", 8'h00, 3'd0, 1'b0, 8'h01, 8'h00);
        bus.rel = 8'h00;
        tick();
        chk_out("g2_after_gap", 8'h04, 3'd2, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        bus.rel = 8'h04;
        tick();
        chk_out("g2_rel", 8'h00, 3'd2, 1'b0, 8'h04, 8'h00);
        bus.rel = 8'h00;

        // Abort in IDLE beats arbitration and resets the pointer.
        bus.req   = 8'hFF;
        bus.abort = 1'b1;
        tick();
        chk_out("idle_abort", 8'h00, 3'd2, 1'b0, 8'h00, 8'h00);
        bus.abort = 1'b0;

        // Full rotation 0..7,0 with release on the third grant cycle.
        for (int k = 0; k < 9; k++) begin
            exp_id = 3'(k % 8);
            oh     = 8'h01 << exp_id;
            tick();
            chk_out("rr_grant", oh, exp_id, 1'b1, 8'h00, 8'h00);
            chk("rr_onehot", 32'($onehot(bus.gnt)), 32'd1);
            bus.rel = ~oh;
            tick();
            chk("rr_other_rel_ignored", 32'(bus.gnt), 32'(oh));
            bus.rel = 8'h00;
            tick();
            chk("rr_hold", 32'(bus.gnt), 32'(oh));
            bus.rel = oh;
            if (k == 8) bus.req = 8'h00;
            tick();
            chk_out("rr_rel", 8'h00, exp_id, 1'b0, oh, 8'h00);
            bus.rel = 8'h00;
        end

        // Timeout of 4 cycles, no release.
        bus.tocyc = 16'd4;
        bus.req   = 8'h02;
        tick();
        chk_out("to_grant", 8'h02, 3'd1, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("to_hold", 32'(bus.gnt), 32'h02);
        end
        tick();
        chk_out("to_expire", 8'h00, 3'd1, 1'b0, 8'h00, 8'h02);
        tick();
        chk_out("to_after", 8'h00, 3'd1, 1'b0, 8'h00, 8'h00);

        // Release on the timeout cycle: done wins, no err.
        bus.req = 8'h08;
        tick();
        chk_out("torel_grant", 8'h08, 3'd3, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("torel_hold", 32'(bus.gnt), 32'h08);
        end
        bus.rel = 8'h08;
        tick();
        chk_out("torel_done", 8'h00, 3'd3, 1'b0, 8'h08, 8'h00);
        bus.rel = 8'h00;
        tick();
        chk_out("torel_after", 8'h00, 3'd3, 1'b0, 8'h00, 8'h00);

        // Abort during a grant, with a coincident release.
        bus.tocyc = 16'd0;
        bus.req   = 8'h10;
        tick();
        chk_out("ab_grant", 8'h10, 3'd4, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        tick();
        tick();
        chk("ab_hold_no_timeout", 32'(bus.gnt), 32'h10);
        bus.abort = 1'b1;
        bus.rel   = 8'h10;
        tick();
        chk_out("ab_drop", 8'h00, 3'd4, 1'b0, 8'h00, 8'h00);
        bus.abort = 1'b0;
        bus.rel   = 8'h00;
        tick();
        chk_out("ab_quiet", 8'h00, 3'd4, 1'b0, 8'h00, 8'h00);
        bus.req = 8'hFF;
        tick();
        chk_out("ab_ptr0", 8'h01, 3'd0, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        bus.rel = 8'h01;
        tick();
        chk_out("ab_ptr0_rel", 8'h00, 3'd0, 1'b0, 8'h01, 8'h00);
        bus.rel = 8'h00;

        // Enable drop during grant, then disabled requester stays ungranted.
        bus.req = 8'h04;
        tick();
        chk_out("en_grant", 8'h04, 3'd2, 1'b1, 8'h00, 8'h00);
        bus.en = 8'hFB;
        tick();
        chk_out("en_drop", 8'h00, 3'd2, 1'b0, 8'h00, 8'h04);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("en_blocked", 8'h00, 3'd2, 1'b0, 8'h00, 8'h00);
        end
        bus.req = 8'h0C;
        tick();
        chk_out("en_other", 8'h08, 3'd3, 1'b1, 8'h00, 8'h00);
        bus.req = 8'h00;
        bus.rel = 8'h08;
        tick();
        chk_out("en_other_rel", 8'h00, 3'd3, 1'b0, 8'h08, 8'h00);
        bus.rel = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
